// File: rtl/serial_ripple_adder.sv
// Bit-serial WIDTH-bit adder: two half-adder stages plus a carry flop, one bit per clock, LSB first.
// Optional subtract mode under `SERIAL_ADD_SUB_EN` (adds the sub port; B inverted, carry seeded with 1).
module serial_ripple_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             start,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             result_valid,
   input  logic             result_ready
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_result;
   logic [CNT_W-1:0] r_count;
   logic             r_carry;
   logic             r_cout;

   logic             w_accept;
   logic             w_last;
   logic [WIDTH-1:0] w_b_load;
   logic             w_cin;
   logic             w_ha1_s;
   logic             w_ha1_c;
   logic             w_ha2_s;
   logic             w_ha2_c;
   logic             w_sum;
   logic             w_carry_nxt;

`ifdef SERIAL_ADD_SUB_EN
   // a - b == a + ~b + 1; carry_out=1 then means no borrow
   assign w_b_load = sub ? ~op_b : op_b;
   assign w_cin    = sub;
`else
   assign w_b_load = op_b;
   assign w_cin    = 1'b0;
`endif

   // Full add from two half adders: (A^B, A&B) then (s1^c, s1&c)
   assign w_ha1_s     = r_a[0] ^ r_b[0];
   assign w_ha1_c     = r_a[0] & r_b[0];
   assign w_ha2_s     = w_ha1_s ^ r_carry;
   assign w_ha2_c     = w_ha1_s & r_carry;
   assign w_sum       = w_ha2_s;
   assign w_carry_nxt = w_ha1_c | w_ha2_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      in_ready     = 1'b0;
      busy         = 1'b0;
      result_valid = 1'b0;
      w_accept     = 1'b0;
      w_last       = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (ena && start) begin
               w_accept    = 1'b1;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            if (ena && (r_count == LAST_CNT)) begin
               w_last      = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            result_valid = 1'b1;
            if (ena && result_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_count  <= '0;
         r_carry  <= 1'b0;
         r_cout   <= 1'b0;
      end else if (ena) begin
         if (w_accept) begin
            r_a      <= op_a;
            r_b      <= w_b_load;
            r_carry  <= w_cin;
            r_count  <= '0;
            r_result <= '0;
         end else if (r_state == S_RUN) begin
            r_a      <= r_a >> 1;
            r_b      <= r_b >> 1;
            r_carry  <= w_carry_nxt;
            r_result <= {w_sum, r_result[WIDTH-1:1]};
            // Counter parks at WIDTH-1 on the final bit rather than wrapping
            if (w_last) r_cout  <= w_carry_nxt;
            else        r_count <= r_count + CNT_W'(1);
         end
      end
   end

   assign result    = r_result;
   assign carry_out = r_cout;

endmodule

// File: tb/tb_serial_ripple_adder.sv
// Self-checking bench for serial_ripple_adder (WIDTH=8); expected sums are queued at start and popped at result.
module tb_serial_ripple_adder;

   localparam int W = 8;

   typedef struct packed {
      logic [W-1:0] res;
      logic         cout;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         ena;
   logic         start;
   logic         in_ready;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         sub;
   logic         busy;
   logic [W-1:0] result;
   logic         carry_out;
   logic         result_valid;
   logic         result_ready;

   exp_t q[$];
   int   n_checks;
   int   n_fails;

   serial_ripple_adder #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ena          (ena),
      .start        (start),
      .in_ready     (in_ready),
      .op_a         (op_a),
      .op_b         (op_b),
`ifdef SERIAL_ADD_SUB_EN
      .sub          (sub),
`endif
      .busy         (busy),
      .result       (result),
      .carry_out    (carry_out),
      .result_valid (result_valid),
      .result_ready (result_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      logic [W:0] full;
      exp_t e;
      if (s) full = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
      else   full = {1'b0, a} + {1'b0, b};
      e.res  = full[W-1:0];
      e.cout = full[W];
      return e;
   endfunction

   task automatic start_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      int guard;
      guard = 0;
      while (!in_ready && guard < 50) begin
         tick();
         guard++;
      end
      check({tag, "_ready"}, 32'(in_ready), 32'd1);
      op_a  = a;
      op_b  = b;
      sub   = s;
      start = 1'b1;
      q.push_back(model(a, b, s));
      tick();
      start = 1'b0;
      check({tag, "_busy"}, 32'(busy), 32'd1);
   endtask

   task automatic wait_valid(input string tag, output int cycles);
      cycles = 0;
      while (!result_valid && cycles < 100) begin
         tick();
         cycles++;
      end
      if (!result_valid) check({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      if (q.size() == 0) begin
         check({tag, "_qempty"}, 32'd0, 32'd1);
      end else begin
         e = q.pop_front();
         check({tag, "_res"}, 32'(result), 32'(e.res));
         check({tag, "_cout"}, 32'(carry_out), 32'(e.cout));
      end
   endtask

   task automatic handshake(input string tag);
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
      check({tag, "_idle"}, 32'(in_ready), 32'd1);
   endtask

   task automatic full_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      int cyc;
      start_op(tag, a, b, s);
      wait_valid(tag, cyc);
      check({tag, "_lat"}, 32'(cyc), 32'd8);
      pop_check(tag);
      handshake(tag);
   endtask

   initial begin
      int cyc;
      int unstable;
      logic [W-1:0] held_res;
      logic         held_cout;
      n_checks     = 0;
      n_fails      = 0;
      rst_n        = 1'b0;
      ena          = 1'b1;
      start        = 1'b0;
      op_a         = '0;
      op_b         = '0;
      sub          = 1'b0;
      result_ready = 1'b0;
      tick();
      tick();
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(result_valid), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_cout", 32'(carry_out), 32'd0);
      rst_n = 1'b1;
      tick();

      // result_ready and start with ena low are both ignored in IDLE
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
      ena   = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      ena   = 1'b1;
      check("ena0_start_busy", 32'(busy), 32'd0);
      check("ena0_start_ready", 32'(in_ready), 32'd1);

      full_op("t1", 8'h3C, 8'h0F, 1'b0);
      full_op("t2", 8'hFF, 8'h01, 1'b0);

      // hold DONE with result_ready low; a start pulse must not be taken
      start_op("t3", 8'h12, 8'h34, 1'b0);
      wait_valid("t3", cyc);
      held_res  = result;
      held_cout = carry_out;
      unstable  = 0;
      for (int i = 0; i < 20; i++) begin
         if (i == 5) begin
            op_a  = 8'hFF;
            op_b  = 8'hFF;
            start = 1'b1;
         end
         if (i == 7) start = 1'b0;
         tick();
         if (result !== held_res || carry_out !== held_cout || !result_valid || in_ready) unstable++;
      end
      check("t3_hold_stable", 32'(unstable), 32'd0);
      pop_check("t3");
      handshake("t3");
      tick();
      check("t3_no_late_start", 32'(busy), 32'd0);

      // ena dropped for 3 cycles after 3 RUN bits
      start_op("t4", 8'hAA, 8'h55, 1'b0);
      tick();
      tick();
      tick();
      ena = 1'b0;
      tick();
      tick();
      tick();
      check("t4_frozen_busy", 32'(busy), 32'd1);
      ena = 1'b1;
      wait_valid("t4", cyc);
      check("t4_lat", 32'(cyc + 6), 32'd11);
      pop_check("t4");
      handshake("t4");

      // asynchronous reset during the 4th RUN cycle
      start_op("t5", 8'h5A, 8'h33, 1'b0);
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("t5_rst_busy", 32'(busy), 32'd0);
      check("t5_rst_ready", 32'(in_ready), 32'd1);
      check("t5_rst_valid", 32'(result_valid), 32'd0);
      check("t5_rst_result", 32'(result), 32'd0);
      check("t5_rst_cout", 32'(carry_out), 32'd0);
      q.delete();
      tick();
      rst_n = 1'b1;
      tick();
      full_op("t5b", 8'h01, 8'h01, 1'b0);

      for (int i = 0; i < 6; i++) begin
         full_op("rnd", 8'($urandom), 8'($urandom), 1'b0);
      end
      full_op("zero", 8'h00, 8'h00, 1'b0);
      full_op("max", 8'hFF, 8'hFF, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
      full_op("t6a", 8'h10, 8'h01, 1'b1);
      full_op("t6b", 8'h01, 8'h02, 1'b1);
      for (int i = 0; i < 4; i++) begin
         full_op("rnd_sub", 8'($urandom), 8'($urandom), 1'b1);
      end
`endif

      check("q_drained", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end

endmodule
